// File: rtl/bus_responder_pkg.sv
// Shared types and address-map constants for the system-bus responder.
// The decode offsets are relative to the start of the I/O page.
package bus_responder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RAM,
      ST_VGA,
      ST_UART,
      ST_ACK
   } state_e;

   typedef enum logic [1:0] {
      TGT_RAM,
      TGT_VGA,
      TGT_UART,
      TGT_NONE
   } target_e;

   localparam int unsigned IO_PAGE_SIZE = 256;
   localparam logic [15:0] VGA_OFS      = 16'd0;
   localparam logic [15:0] VGA_REGS     = 16'd4;
   localparam logic [15:0] UART_OFS     = 16'd4;
   localparam logic [15:0] UART_REGS    = 16'd2;
   localparam logic [7:0]  DAT_BAD      = 8'hFF;
   localparam logic [7:0]  DAT_WR       = 8'h00;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: bus address -> target slave and register sub-address.
// Anything at or above IO_BASE that is not a known register is unmapped.
module bus_addr_decode
   import bus_responder_pkg::*;
#(
   parameter logic [15:0] IO_BASE = 16'hFE00
) (
   input  logic [15:0] addr_i,
   output target_e     tgt_o,
   output logic [1:0]  sub_o
);

   logic [15:0] ofs;
   logic [15:0] vofs;
   logic [15:0] uofs;

   // Offsets wrap when below the window base, so a single unsigned compare bounds each window.
   assign ofs  = addr_i - IO_BASE;
   assign vofs = ofs - VGA_OFS;
   assign uofs = ofs - UART_OFS;

   always_comb begin
      tgt_o = TGT_NONE;
      sub_o = 2'd0;
      if (addr_i < IO_BASE) begin
         tgt_o = TGT_RAM;
      end else if (ofs < 16'(IO_PAGE_SIZE)) begin
         if (vofs < VGA_REGS) begin
            tgt_o = TGT_VGA;
            sub_o = vofs[1:0];
         end else if (uofs < UART_REGS) begin
            tgt_o = TGT_UART;
            sub_o = {1'b0, uofs[0]};
         end
      end
   end

endmodule

// File: rtl/bus_responder.sv
// Slave-side terminator of the 8-bit system bus: decodes a request to SRAM, VGA or UART,
// runs the target's strobe/wait sequence and returns a single-cycle ack with read data.
module bus_responder
   import bus_responder_pkg::*;
#(
   parameter int unsigned RAM_WAIT = 1,
   parameter int unsigned TIMEOUT  = 15,
   parameter logic [15:0] IO_BASE  = 16'hFE00
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [15:0] i_addr,
   input  logic [7:0]  i_dat,
   output logic [7:0]  o_dat,
   input  logic        i_cs,
   input  logic        i_we,
   output logic        o_ack,
   output logic [15:0] o_ram_addr,
   output logic [7:0]  o_ram_dat,
   input  logic [7:0]  i_ram_dat,
   output logic        o_ram_ce_n,
   output logic        o_ram_oe_n,
   output logic        o_ram_we_n,
   output logic [1:0]  o_vga_addr,
   output logic [7:0]  o_vga_dat,
   input  logic [7:0]  i_vga_dat,
   output logic        o_vga_cs,
   output logic        o_vga_we,
   output logic        o_uart_addr,
   output logic [7:0]  o_uart_dat,
   input  logic [7:0]  i_uart_dat,
   output logic        o_uart_cs,
   output logic        o_uart_we,
   input  logic        i_uart_ack,
   output logic        o_timeout_err
);

   state_e      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdat_q, wdat_d;
   logic        we_q, we_d;
   logic [1:0]  sub_q, sub_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  rdat_q, rdat_d;
   logic        err_q, err_d;

   target_e     dec_tgt;
   logic [1:0]  dec_sub;

   bus_addr_decode #(.IO_BASE(IO_BASE)) u_dec (
      .addr_i (i_addr),
      .tgt_o  (dec_tgt),
      .sub_o  (dec_sub)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= ST_IDLE;
         addr_q  <= 16'd0;
         wdat_q  <= 8'd0;
         we_q    <= 1'b0;
         sub_q   <= 2'd0;
         cnt_q   <= 8'd0;
         rdat_q  <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         we_q    <= we_d;
         sub_q   <= sub_d;
         cnt_q   <= cnt_d;
         rdat_q  <= rdat_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      we_d    = we_q;
      sub_d   = sub_q;
      cnt_d   = cnt_q;
      rdat_d  = rdat_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (i_cs) begin
               addr_d = i_addr;
               wdat_d = i_dat;
               we_d   = i_we;
               sub_d  = dec_sub;
               unique case (dec_tgt)
                  TGT_RAM: begin
                     state_d = ST_RAM;
                     cnt_d   = 8'(RAM_WAIT);
                  end
                  TGT_VGA:  state_d = ST_VGA;
                  TGT_UART: begin
                     state_d = ST_UART;
                     cnt_d   = 8'(TIMEOUT);
                  end
                  default: begin
                     state_d = ST_ACK;
                     rdat_d  = DAT_BAD;
                  end
               endcase
            end
         end
         ST_RAM: begin
            if (cnt_q == 8'd0) begin
               rdat_d  = we_q ? DAT_WR : i_ram_dat;
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_VGA: begin
            rdat_d  = we_q ? DAT_WR : i_vga_dat;
            state_d = ST_ACK;
         end
         ST_UART: begin
            // A slave ack arriving on the expiry cycle still counts as success.
            if (i_uart_ack) begin
               rdat_d  = we_q ? DAT_WR : i_uart_dat;
               state_d = ST_ACK;
            end else if (cnt_q == 8'd0) begin
               rdat_d  = DAT_BAD;
               err_d   = 1'b1;
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign o_ack         = (state_q == ST_ACK);
   assign o_dat         = rdat_q;
   assign o_timeout_err = err_q;

   assign o_ram_addr    = addr_q;
   assign o_ram_dat     = wdat_q;
   assign o_ram_ce_n    = ~(state_q == ST_RAM);
   assign o_ram_oe_n    = ~((state_q == ST_RAM) & ~we_q);
   assign o_ram_we_n    = ~((state_q == ST_RAM) & we_q);

   assign o_vga_addr    = sub_q;
   assign o_vga_dat     = wdat_q;
   assign o_vga_cs      = (state_q == ST_VGA);
   assign o_vga_we      = (state_q == ST_VGA) & we_q;

   assign o_uart_addr   = sub_q[0];
   assign o_uart_dat    = wdat_q;
   assign o_uart_cs     = (state_q == ST_UART);
   assign o_uart_we     = (state_q == ST_UART) & we_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: SRAM, VGA, UART, timeout, unmapped and mid-transfer reset.
// A second instance with RAM_WAIT=3 is used for the reset-abort scenario.
module tb_bus_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] addr;
   logic [7:0]  wdat;
   logic        cs, cs3, we;
   logic [7:0]  vga_rdat, uart_rdat;
   logic        uart_ack;

   logic [7:0]  dat, dat3;
   logic        ack, ack3;
   logic [15:0] ram_addr, ram3_addr;
   logic [7:0]  ram_wdat, ram3_wdat, ram_rdat, ram3_rdat;
   logic        ce_n, oe_n, we_n, ce3_n, oe3_n, we3_n;
   logic [1:0]  vga_addr, vga3_addr;
   logic [7:0]  vga_wdat, vga3_wdat;
   logic        vga_cs, vga_we, vga3_cs, vga3_we;
   logic        uart_addr, uart3_addr;
   logic [7:0]  uart_wdat, uart3_wdat;
   logic        uart_cs, uart_we, uart3_cs, uart3_we;
   logic        err, err3;

   logic [7:0]  mem [0:65535];

   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (!we_n) mem[ram_addr] <= ram_wdat;
   assign ram_rdat  = mem[ram_addr];
   assign ram3_rdat = 8'h5A;

   bus_responder dut (
      .i_clk(clk), .i_reset(rst_n), .i_addr(addr), .i_dat(wdat), .o_dat(dat),
      .i_cs(cs), .i_we(we), .o_ack(ack),
      .o_ram_addr(ram_addr), .o_ram_dat(ram_wdat), .i_ram_dat(ram_rdat),
      .o_ram_ce_n(ce_n), .o_ram_oe_n(oe_n), .o_ram_we_n(we_n),
      .o_vga_addr(vga_addr), .o_vga_dat(vga_wdat), .i_vga_dat(vga_rdat),
      .o_vga_cs(vga_cs), .o_vga_we(vga_we),
      .o_uart_addr(uart_addr), .o_uart_dat(uart_wdat), .i_uart_dat(uart_rdat),
      .o_uart_cs(uart_cs), .o_uart_we(uart_we), .i_uart_ack(uart_ack),
      .o_timeout_err(err)
   );

   bus_responder #(.RAM_WAIT(3)) dut3 (
      .i_clk(clk), .i_reset(rst_n), .i_addr(addr), .i_dat(wdat), .o_dat(dat3),
      .i_cs(cs3), .i_we(we), .o_ack(ack3),
      .o_ram_addr(ram3_addr), .o_ram_dat(ram3_wdat), .i_ram_dat(ram3_rdat),
      .o_ram_ce_n(ce3_n), .o_ram_oe_n(oe3_n), .o_ram_we_n(we3_n),
      .o_vga_addr(vga3_addr), .o_vga_dat(vga3_wdat), .i_vga_dat(vga_rdat),
      .o_vga_cs(vga3_cs), .o_vga_we(vga3_we),
      .o_uart_addr(uart3_addr), .o_uart_dat(uart3_wdat), .i_uart_dat(uart_rdat),
      .o_uart_cs(uart3_cs), .o_uart_we(uart3_we), .i_uart_ack(uart_ack),
      .o_timeout_err(err3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; cs = 1'b0; cs3 = 1'b0; we = 1'b0; addr = 16'h0; wdat = 8'h0;
      vga_rdat = 8'h00; uart_rdat = 8'h00; uart_ack = 1'b0;
      step(2);
      chk("rst_ack",     {31'd0, ack}, 32'd0);
      chk("rst_dat",     {24'd0, dat}, 32'd0);
      chk("rst_strobes", {29'd0, ce_n, oe_n, we_n}, 32'h7);
      chk("rst_cs",      {30'd0, vga_cs, uart_cs}, 32'd0);
      chk("rst_err",     {31'd0, err}, 32'd0);
      chk("rst_raddr",   {16'd0, ram_addr}, 32'd0);
      rst_n = 1'b1;
      step();

      // RAM write 0x1234 <- 0xA5
      cs = 1'b1; addr = 16'h1234; wdat = 8'hA5; we = 1'b1;
      step();
      chk("ramw_strb0",  {29'd0, ce_n, oe_n, we_n}, 32'b010);
      chk("ramw_addr",   {16'd0, ram_addr}, 32'h1234);
      chk("ramw_wdat",   {24'd0, ram_wdat}, 32'hA5);
      chk("ramw_ack0",   {31'd0, ack}, 32'd0);
      cs = 1'b0; addr = 16'h0000; wdat = 8'h00;
      step();
      chk("ramw_strb1",  {29'd0, ce_n, oe_n, we_n}, 32'b010);
      chk("ramw_latch",  {16'd0, ram_addr}, 32'h1234);
      step();
      chk("ramw_ack",    {31'd0, ack}, 32'd1);
      chk("ramw_dat",    {24'd0, dat}, 32'h00);
      chk("ramw_strb2",  {29'd0, ce_n, oe_n, we_n}, 32'b111);
      step();
      chk("ramw_ackend", {31'd0, ack}, 32'd0);

      // RAM read back
      cs = 1'b1; addr = 16'h1234; we = 1'b0;
      step();
      chk("ramr_strb0",  {29'd0, ce_n, oe_n, we_n}, 32'b001);
      cs = 1'b0;
      step();
      chk("ramr_ack0",   {31'd0, ack}, 32'd0);
      step();
      chk("ramr_ack",    {31'd0, ack}, 32'd1);
      chk("ramr_dat",    {24'd0, dat}, 32'hA5);
      step();

      // VGA write IO_BASE+1 <- 0x42
      cs = 1'b1; addr = 16'hFE01; wdat = 8'h42; we = 1'b1;
      step();
      chk("vgaw_cswe",   {30'd0, vga_cs, vga_we}, 32'b11);
      chk("vgaw_addr",   {30'd0, vga_addr}, 32'd1);
      chk("vgaw_wdat",   {24'd0, vga_wdat}, 32'h42);
      chk("vgaw_ramidle",{31'd0, ce_n}, 32'd1);
      cs = 1'b0;
      step();
      chk("vgaw_ack",    {30'd0, ack, vga_cs}, 32'b10);
      chk("vgaw_dat",    {24'd0, dat}, 32'h00);
      step();

      // VGA read IO_BASE+2, slave returns 0x3C
      cs = 1'b1; addr = 16'hFE02; we = 1'b0; vga_rdat = 8'h3C;
      step();
      chk("vgar_cswe",   {30'd0, vga_cs, vga_we}, 32'b10);
      chk("vgar_addr",   {30'd0, vga_addr}, 32'd2);
      chk("vgar_ack0",   {31'd0, ack}, 32'd0);
      cs = 1'b0;
      step();
      chk("vgar_ack",    {30'd0, ack, vga_cs}, 32'b10);
      chk("vgar_dat",    {24'd0, dat}, 32'h3C);
      step();

      // UART read IO_BASE+5, slave acks 4 cycles into the access
      cs = 1'b1; addr = 16'hFE05; we = 1'b0;
      step();
      chk("uart_cs",     {30'd0, uart_cs, uart_we}, 32'b10);
      chk("uart_addr",   {31'd0, uart_addr}, 32'd1);
      cs = 1'b0;
      step(3);
      chk("uart_wait",   {30'd0, ack, uart_cs}, 32'b01);
      step();
      uart_ack = 1'b1; uart_rdat = 8'h7E;
      step();
      chk("uart_ack",    {30'd0, ack, uart_cs}, 32'b10);
      chk("uart_dat",    {24'd0, dat}, 32'h7E);
      chk("uart_noerr",  {31'd0, err}, 32'd0);
      uart_ack = 1'b0;
      step();

      // UART read IO_BASE+4 with no slave ack -> timeout
      cs = 1'b1; addr = 16'hFE04;
      step();
      chk("tmo_addr",    {31'd0, uart_addr}, 32'd0);
      cs = 1'b0;
      step(15);
      chk("tmo_wait",    {30'd0, ack, uart_cs}, 32'b01);
      chk("tmo_err0",    {31'd0, err}, 32'd0);
      step();
      chk("tmo_ack",     {30'd0, ack, uart_cs}, 32'b10);
      chk("tmo_dat",     {24'd0, dat}, 32'hFF);
      chk("tmo_err",     {31'd0, err}, 32'd1);
      step();

      // Unmapped read IO_BASE+0x80 with i_cs held high
      cs = 1'b1; addr = 16'hFE80;
      step();
      chk("unm_ack",     {31'd0, ack}, 32'd1);
      chk("unm_dat",     {24'd0, dat}, 32'hFF);
      chk("unm_nostrb",  {29'd0, vga_cs, uart_cs, ce_n}, 32'b001);
      step();
      chk("unm_gap",     {31'd0, ack}, 32'd0);
      step();
      chk("unm_ack2",    {31'd0, ack}, 32'd1);
      cs = 1'b0;
      step();
      chk("unm_end",     {31'd0, ack}, 32'd0);
      chk("tmo_sticky",  {31'd0, err}, 32'd1);

      // Reset in the middle of a RAM_WAIT=3 write
      cs3 = 1'b1; addr = 16'h0100; wdat = 8'h11; we = 1'b1;
      step();
      chk("rst3_strb0",  {29'd0, ce3_n, oe3_n, we3_n}, 32'b010);
      cs3 = 1'b0;
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("rst3_abort",  {29'd0, ce3_n, oe3_n, we3_n}, 32'b111);
      chk("rst3_noack",  {31'd0, ack3}, 32'd0);
      chk("rst_errclr",  {31'd0, err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      cs3 = 1'b1; addr = 16'h0200; we = 1'b0;
      step();
      cs3 = 1'b0;
      chk("rd3_strb0",   {29'd0, ce3_n, oe3_n, we3_n}, 32'b001);
      step(3);
      chk("rd3_ack0",    {31'd0, ack3}, 32'd0);
      step();
      chk("rd3_ack",     {31'd0, ack3}, 32'd1);
      chk("rd3_dat",     {24'd0, dat3}, 32'h5A);
      step();
      chk("rd3_end",     {31'd0, ack3}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/bus_responder.md
# bus_responder

Slave-side terminator of the shared 8-bit system bus: takes the arbitrated master stream (16-bit address, cs, we, 8-bit data) and answers it. It decodes each request to external async SRAM, the VGA text slave registers or the UART slave registers. It runs the strobe and wait-state sequence for the selected target and returns a single-cycle ack with read data. It sits between the bus arbiter shell and the memory/peripheral slaves, and generates the ack the masters wait on.

## Interface
- RAM_WAIT, 1: extra SRAM access cycles (0..15)
- TIMEOUT, 15: max cycles waiting for UART ack (1..255)
- IO_BASE, 16'hFE00: start of I/O page (256 bytes); below it is RAM
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_addr  in  16  bus address
- i_dat  in  8  bus write data
- o_dat  out  8  read data, valid while o_ack
- i_cs  in  1  request
- i_we  in  1  1 = write
- o_ack  out  1  one-cycle completion pulse
- o_ram_addr  out  16; o_ram_dat  out  8; i_ram_dat  in  8; o_ram_ce_n, o_ram_oe_n, o_ram_we_n  out  1 each: SRAM pins
- o_vga_addr  out  2; o_vga_dat  out  8; i_vga_dat  in  8; o_vga_cs, o_vga_we  out  1: VGA slave port
- o_uart_addr  out  1; o_uart_dat  out  8; i_uart_dat  in  8; o_uart_cs, o_uart_we  out  1; i_uart_ack  in  1: UART slave port
- o_timeout_err  out  1  sticky UART timeout flag

## Operation
- Decode on latched address: < IO_BASE → RAM; IO_BASE+0..3 → VGA (addr[1:0]); IO_BASE+4..5 → UART (addr[0]); any other I/O address → unmapped.
- States: IDLE, RAM, VGA, UART, ACK.
- IDLE: on i_cs=1, latch addr/dat/we, go to target state. Counter loads RAM_WAIT for RAM, TIMEOUT for UART. Unmapped goes straight to ACK with o_dat=8'hFF; writes are dropped.
- RAM: ce_n=0; oe_n=~we; we_n=we?0:1; counter decrements. At 0, capture i_ram_dat (reads) and go to ACK.
- VGA: o_vga_cs=1 for exactly one cycle, o_vga_we=latched we. Capture i_vga_dat and go to ACK.
- UART: o_uart_cs held until i_uart_ack=1, then capture i_uart_dat and go to ACK. If counter reaches 0 first: o_dat=8'hFF, set o_timeout_err, drop cs, go to ACK.
- ACK: o_ack=1 for one cycle, o_dat holds captured value. Go to IDLE.
- Write cycles return o_dat=8'h00.
- o_timeout_err clears only on reset.

## Timing
- Reset (async, i_reset=0): state IDLE; o_ack=0; o_dat=0; o_ram_ce_n/oe_n/we_n=1; o_vga_cs=o_uart_cs=0; o_vga_we=o_uart_we=0; o_timeout_err=0; address/data outputs 0.
- Reset asserted mid-transfer aborts the transfer immediately. No ack is issued and no write is guaranteed.
- Latency, counted as clock edges from the edge that samples i_cs to the first cycle with o_ack=1: RAM = RAM_WAIT+2; VGA = 2; UART = k+2 with i_uart_ack at k cycles into UART; unmapped = 1; timeout = TIMEOUT+2.
- Latched request is immune to i_cs/i_addr changes after sampling. Dropping i_cs mid-transfer still completes and acks.
- i_cs is ignored outside IDLE. Back-to-back requests therefore have a minimum one-cycle gap after the ack cycle.
- Masters must drop i_cs or present the next request in the cycle after o_ack. A still-high i_cs in IDLE starts a new transaction.
- SRAM address/data/strobes all change on the same edge. Strobes stay high in every non-RAM state.
- i_uart_ack and counter expiry in the same cycle: the ack wins and there is no error.

## Structure
- Package bus_responder_pkg: state enum; target enum (RAM, VGA, UART, NONE); offsets VGA_OFS=0, UART_OFS=4; IO_PAGE_SIZE=256.
- Sub-module bus_addr_decode: combinational, address → target plus sub-address. Shared with future slaves.
- One down-counter, 8-bit, shared by the RAM wait and the UART timeout.

## Test plan
- RAM write 0x1234←0xA5, then read 0x1234, RAM_WAIT=1 → we_n low 2 cycles; ack 3 cycles after sample; read o_dat=0xA5.
- VGA read IO_BASE+2 with i_vga_dat=0x3C → o_vga_cs one cycle, o_vga_addr=2, ack at cycle 2, o_dat=0x3C.
- UART read IO_BASE+5, i_uart_ack after 4 cycles, i_uart_dat=0x7E → o_uart_addr=1, ack at cycle 6, o_dat=0x7E, no error.
- UART read, never ack, TIMEOUT=15 → ack at cycle 17, o_dat=0xFF, o_timeout_err=1 and remains set.
- Unmapped read IO_BASE+0x80 → ack next cycle, o_dat=0xFF, no peripheral strobe; i_cs held high continuously → new transaction one cycle after ack.
- Reset pulsed during RAM access with RAM_WAIT=3 → all strobes high and o_ack=0 immediately; next request after release completes normally.
